// File: rtl/gate_tt_checker.sv
// Sequential truth-table exerciser for a 2-input gate: drives all four {a,b} vectors,
// samples y after a settle time and scores it against an expected table.
module gate_tt_checker #(
    parameter logic [3:0]  EXP_TT = 4'b0111,
    parameter int unsigned SETTLE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_y_in,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [2:0] o_err_cnt,
    output logic [3:0] o_err_mask
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_t;

    localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

    state_t     r_state, w_state;
    logic [1:0] r_idx, w_idx;
    logic [3:0] r_cnt, w_cnt;
    logic       r_a, w_a;
    logic       r_b, w_b;
    logic       r_busy, w_busy;
    logic       r_done, w_done;
    logic       r_pass, w_pass;
    logic [2:0] r_err_cnt, w_err_cnt;
    logic [3:0] r_err_mask, w_err_mask;
    logic       w_miss;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_idx      <= 2'd0;
            r_cnt      <= 4'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 3'd0;
            r_err_mask <= 4'd0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_a        <= w_a;
            r_b        <= w_b;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_pass     <= w_pass;
            r_err_cnt  <= w_err_cnt;
            r_err_mask <= w_err_mask;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_a        = r_a;
        w_b        = r_b;
        w_busy     = r_busy;
        w_done     = r_done;
        w_pass     = r_pass;
        w_err_cnt  = r_err_cnt;
        w_err_mask = r_err_mask;
        w_miss     = 1'b0;

        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state    = StSettle;
                    w_idx      = 2'd0;
                    w_cnt      = CntLoad;
                    w_a        = 1'b0;
                    w_b        = 1'b0;
                    w_busy     = 1'b1;
                    w_done     = 1'b0;
                    w_pass     = 1'b0;
                    w_err_cnt  = 3'd0;
                    w_err_mask = 4'd0;
                end
            end
            StSettle: begin
                if (r_cnt == 4'd0) begin
                    w_state = StCheck;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            StCheck: begin
                // Case-inequality so an X/Z gate output is scored as a failure.
                w_miss            = (i_y_in !== EXP_TT[r_idx]);
                w_err_cnt         = r_err_cnt + {2'd0, w_miss};
                w_err_mask[r_idx] = r_err_mask[r_idx] | w_miss;
                if (r_idx == 2'd3) begin
                    w_state = StDone;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_err_cnt == 3'd0);
                end else begin
                    w_state    = StSettle;
                    w_idx      = r_idx + 2'd1;
                    {w_a, w_b} = r_idx + 2'd1;
                    w_cnt      = CntLoad;
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_err_cnt  = r_err_cnt;
    assign o_err_mask = r_err_mask;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: a modelled gate (NAND, stuck-at-1 or AND) closes the loop.
module tb_gate_tt_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    int         mode0 = 0;
    logic       y0, y1;
    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] cnt0;
    logic [3:0] mask0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] cnt1;
    logic [3:0] mask1;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    // mode0: 0 = NAND, 1 = stuck-at-1, 2 = AND
    assign y0 = (mode0 == 1) ? 1'b1 : (mode0 == 2) ? (a0 & b0) : ~(a0 & b0);
    assign y1 = ~(a1 & b1);

    gate_tt_checker #(.EXP_TT(4'b0111), .SETTLE(2)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_y_in(y0),
        .o_a(a0), .o_b(b0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
        .o_err_cnt(cnt0), .o_err_mask(mask0)
    );

    gate_tt_checker #(.EXP_TT(4'b0111), .SETTLE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_y_in(y1),
        .o_a(a1), .o_b(b1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_cnt(cnt1), .o_err_mask(mask1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({a0, b0, busy0, done0, pass0, cnt0, mask0} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_dut0: got %b want 0", {a0, b0, busy0, done0, pass0, cnt0, mask0});
        end
        n_cmp++;
        if ({a1, b1, busy1, done1, pass1, cnt1, mask1} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_dut1: got %b want 0", {a1, b1, busy1, done1, pass1, cnt1, mask1});
        end
        rst_n = 1'b1;
        tick();
    endtask

    // restart_at: edge offset at which a spurious start is pulsed (-1 for none)
    task automatic run_nand_timed(input string name, input int restart_at);
        logic [1:0] exp_ab;
        mode0  = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_ab = 2'(k / 3);
            n_cmp++;
            if ({a0, b0} !== exp_ab) begin
                n_bad++;
                $display("FAIL %s_ab@E0+%0d: got %b want %b", name, k, {a0, b0}, exp_ab);
            end
            n_cmp++;
            if (busy0 !== 1'b1 || done0 !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_busy@E0+%0d: got busy=%b done=%b want 1 0", name, k, busy0, done0);
            end
            start0 = (k == restart_at - 1);
            tick();
        end
        start0 = 1'b0;
        n_cmp++;
        if ({busy0, done0, pass0, cnt0, mask0, a0, b0} !== {3'b011, 3'd0, 4'd0, 2'b11}) begin
            n_bad++;
            $display("FAIL %s_final: got busy=%b done=%b pass=%b cnt=%0d mask=%b ab=%b want 0 1 1 0 0000 11",
                     name, busy0, done0, pass0, cnt0, mask0, {a0, b0});
        end
    endtask

    task automatic test_nand_run;
        run_nand_timed("nand", -1);
    endtask

    task automatic test_busy_start_ignored;
        run_nand_timed("busy_start", 5);
    endtask

    task automatic run_mode(input int mode, input logic [2:0] exp_cnt, input logic [3:0] exp_mask,
                            input string name);
        mode0  = mode;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (12) tick();
        n_cmp++;
        if ({done0, pass0, busy0, cnt0, mask0} !== {1'b1, (exp_cnt == 3'd0), 1'b0, exp_cnt, exp_mask}) begin
            n_bad++;
            $display("FAIL %s: got done=%b pass=%b busy=%b cnt=%0d mask=%b want 1 %b 0 %0d %b",
                     name, done0, pass0, busy0, cnt0, mask0, (exp_cnt == 3'd0), exp_cnt, exp_mask);
        end
    endtask

    task automatic test_stuck_at_1;
        run_mode(1, 3'd1, 4'b1000, "stuck1");
    endtask

    task automatic test_and_gate;
        run_mode(2, 3'd4, 4'b1111, "and_gate");
    endtask

    task automatic test_mid_reset;
        mode0  = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({a0, b0, busy0, done0, pass0, cnt0, mask0} !== 12'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want 0", {a0, b0, busy0, done0, pass0, cnt0, mask0});
        end
        repeat (3) tick();
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_idle: got busy=%b done=%b want 0 0", busy0, done0);
        end
        run_mode(0, 3'd0, 4'd0, "after_reset_run");
    endtask

    task automatic test_recover_after_fail;
        run_mode(1, 3'd1, 4'b1000, "pre_fail");
        mode0  = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_cmp++;
        if ({busy0, done0, pass0, cnt0, mask0} !== {3'b100, 3'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL restart_clear: got busy=%b done=%b pass=%b cnt=%0d mask=%b want 1 0 0 0 0000",
                     busy0, done0, pass0, cnt0, mask0);
        end
        repeat (12) tick();
        n_cmp++;
        if ({done0, pass0, cnt0, mask0} !== {2'b11, 3'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL recover_final: got done=%b pass=%b cnt=%0d mask=%b want 1 1 0 0000",
                     done0, pass0, cnt0, mask0);
        end
    endtask

    task automatic test_settle1;
        logic [1:0] exp_ab;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_ab = 2'(k / 2);
            n_cmp++;
            if ({a1, b1} !== exp_ab || done1 !== 1'b0 || busy1 !== 1'b1) begin
                n_bad++;
                $display("FAIL settle1@E0+%0d: got ab=%b done=%b busy=%b want %b 0 1",
                         k, {a1, b1}, done1, busy1, exp_ab);
            end
            tick();
        end
        n_cmp++;
        if ({done1, pass1, busy1, cnt1, mask1} !== {3'b110, 3'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL settle1_final: got done=%b pass=%b busy=%b cnt=%0d mask=%b want 1 1 0 0 0000",
                     done1, pass1, busy1, cnt1, mask1);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_nand_run();
        test_stuck_at_1();
        test_and_gate();
        test_busy_start_ignored();
        test_mid_reset();
        test_recover_after_fail();
        test_settle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Sequential truth-table exerciser that sits directly around a 2-input gate (e.g. the lab NAND).
- Drives the gate's `a`/`b` inputs through all four combinations from registered outputs.
- Samples the gate's `y` after a programmable settle time and compares it with an expected 4-entry truth table.
- Reports an error count, a per-vector error mask, and pass/done, so gate labs can be self-checked in hardware or in simulation.

Parameters:
- EXP_TT, 4'b0111, expected `y` per vector; bit index = {a,b}. Default is NAND: 00→1, 01→1, 10→1, 11→0.
- SETTLE, 2, cycles `a`/`b` are held stable before `y` is sampled. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- y_in  input  1  output of the gate under test.
- a  output  1  registered drive to gate input a.
- b  output  1  registered drive to gate input b.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  valid while done=1; 1 iff err_cnt==0.
- err_cnt  output  3  number of mismatching vectors (0..4).
- err_mask  output  4  bit i set iff vector i ({a,b}=i) mismatched.

Behaviour:
- Reset: sampled on a rising clk edge with rst_n=0. State→IDLE; a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, err_mask=0; internal idx=0, settle counter=0. Reset overrides start, and overrides a run in progress: no partial result is retained.
- FSM states:
  - IDLE: no run active.
  - SETTLE: vector applied, counting down the settle time.
  - CHECK: sample y_in and score the current vector.
  - DONE: run complete, results held.
- IDLE/DONE + start=1 at edge E0:
  - Clear err_cnt, err_mask, done and pass.
  - Set idx=0 and {a,b}=2'b00.
  - Set busy=1 and load the settle counter with SETTLE-1.
  - Go to SETTLE.
- SETTLE:
  - Decrement the counter each edge; go to CHECK on the edge where the counter is 0.
  - The state therefore lasts exactly SETTLE cycles.
  - {a,b} does not change in this state.
- CHECK (one cycle): compare y_in with EXP_TT[idx] at the edge. Mismatch uses case-inequality, so X/Z on y_in counts as an error. On mismatch, err_cnt+1 and err_mask[idx]=1.
  - If idx<3: idx+1, {a,b}=idx+1, reload the counter with SETTLE-1, return to SETTLE.
  - If idx==3: go to DONE; busy=0, done=1, pass=(final err_cnt==0). The final err_cnt includes this cycle's result.
- Latency:
  - Each vector takes SETTLE+1 cycles; a run takes 4·(SETTLE+1) cycles.
  - With defaults, the CHECK edges fall at E0+3, +6, +9 and +12, and done=1 after edge E0+12.
- start while busy=1 is ignored: no restart and no effect on results.
- DONE:
  - All results are held, and {a,b} holds 2'b11.
  - start=1 begins a new run exactly as from IDLE.
  - done/pass fall on the accepting edge, and err_cnt/err_mask clear on that same edge.
- err_cnt cannot overflow: at most 4 increments per run.
- All outputs are registered; no combinational path from y_in or start to any output.

Test Plan:
- NAND DUT, defaults; reset, then start pulsed 1 cycle at E0:
  - a/b sequence 00, 01, 10, 11, each held 3 cycles.
  - busy high from E0 to E0+12; done=1 after E0+12.
  - pass=1, err_cnt=0, err_mask=0000.
- y_in tied to 1 (stuck-at-1), defaults: after the run, err_cnt=1, err_mask=4'b1000, pass=0, done=1.
- AND DUT with EXP_TT=4'b0111: all four vectors mismatch; err_cnt=4, err_mask=4'b1111, pass=0.
- start re-pulsed at E0+5 while busy: ignored; the run completes at E0+12 with the same timing and results as the first scenario.
- rst_n=0 for one cycle at E0+7 mid-run: at the next edge all outputs are at reset values (a=b=0, busy=0, done=0, err_cnt=0). A fresh start then yields a correct full run.
- After a failing run (err_cnt=1), start with a good NAND DUT: err_cnt/err_mask clear on the start edge and done drops. The run ends with pass=1, err_cnt=0. SETTLE=1 variant: done after E0+8.
